washer_sensor_unit: RTL

- Plant/sensor side of the washing-machine controller interface. Consumes actuator commands (fill valve, drain valve, motor, door lock) and produces the sensor/status signals the controller waits on: door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout.
- Used as the closed-loop partner of the controller in system simulation and FPGA demo.
- Models the water level, wash and spin interval timers, the door latch and the detergent dispenser. Also flags illegal actuator combinations.

---
 rtl/washer_pkg.sv | 21 ++
 rtl/washer_interval_timer.sv | 37 +++
 rtl/washer_sensor_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/washer_pkg.sv
// Shared constants for the washing-machine controller/plant pair: controller state
// encoding and default plant timing.
package washer_pkg;

  typedef enum logic [2:0] {
    CHECK_DOOR    = 3'd0,
    FILL_WATER    = 3'd1,
    ADD_DETERGENT = 3'd2,
    CYCLE         = 3'd3,
    DRAIN_WATER   = 3'd4,
    SPIN          = 3'd5
  } ctrl_state_e;

  localparam int DEF_TICK_DIV    = 4;
  localparam int DEF_LEVEL_W     = 4;
  localparam int DEF_LEVEL_MAX   = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_CYCLE_TICKS = 10;
  localparam int DEF_SPIN_TICKS  = 6;

endpackage

// File: rtl/washer_interval_timer.sv
// Enable-gated tick counter: clears whenever en is low, counts ticks up to TICKS,
// and flags timeout while parked at TICKS.
module washer_interval_timer #(
  parameter int CNT_W = 8,
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  output logic timeout
);

  localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick && (cnt_q < TICKS_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == TICKS_C);

endmodule

// File: rtl/washer_sensor_unit.sv
// Plant model for the washer controller: water level, wash/spin timers, door latch,
// detergent dispenser and a sticky flag for illegal actuator combinations.
module washer_sensor_unit
  import washer_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int LEVEL_MAX   = DEF_LEVEL_MAX,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fill_valve_on,
  input  logic               drain_valve_on,
  input  logic               motor_on,
  input  logic               door_lock,
  input  logic               door_close_cmd,
  input  logic               door_open_cmd,
  input  logic               detergent_load,
  output logic               door_close,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] level,
  output logic               fault
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(LEVEL_MAX);

  logic [PW-1:0]      presc_q, presc_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               door_q, door_d;
  logic               det_q, det_d;
  logic               fault_q, fault_d;
  logic               tick;
  logic               spin_en;
  logic               illegal;

  assign tick    = (presc_q == PRESC_LAST);
  // Spin only once the tub is empty; uses the registered drained decode.
  assign spin_en = drain_valve_on & drained & ~fill_valve_on;
  assign illegal = (fill_valve_on & drain_valve_on) |
                   ((fill_valve_on | drain_valve_on | motor_on) & ~door_q);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);

    level_d = level_q;
    if (tick) begin
      if (fill_valve_on && !drain_valve_on && (level_q < LEVEL_FULL)) begin
        level_d = level_q + LEVEL_W'(1);
      end else if (drain_valve_on && !fill_valve_on && (level_q != '0)) begin
        level_d = level_q - LEVEL_W'(1);
      end
    end

    door_d = door_q;
    if (door_close_cmd) begin
      door_d = 1'b1;
    end else if (door_open_cmd && !door_lock) begin
      door_d = 1'b0;
    end

    det_d = det_q;
    if (motor_on) begin
      det_d = 1'b0;
    end else if (detergent_load) begin
      det_d = 1'b1;
    end

    fault_d = fault_q | illegal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      level_q <= '0;
      door_q  <= 1'b0;
      det_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      level_q <= level_d;
      door_q  <= door_d;
      det_q   <= det_d;
      fault_q <= fault_d;
    end
  end

  washer_interval_timer #(
    .CNT_W (CNT_W),
    .TICKS (CYCLE_TICKS)
  ) u_cycle_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (motor_on),
    .tick    (tick),
    .timeout (cycle_timeout)
  );

  washer_interval_timer #(
    .CNT_W (CNT_W),
    .TICKS (SPIN_TICKS)
  ) u_spin_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (spin_en),
    .tick    (tick),
    .timeout (spin_timeout)
  );

  assign level           = level_q;
  assign filled          = (level_q == LEVEL_FULL);
  assign drained         = (level_q == '0);
  assign door_close      = door_q;
  assign detergent_added = det_q;
  assign fault           = fault_q;

endmodule
